watch_time_counter: RTL and testbench

Running MM:SS timekeeper for the watch project, sitting directly downstream of the button-driven digit-setting stage. It accepts four preset BCD digits in the same encoding that stage produces (minutes tens 0–5, minutes units 0–9, seconds tens 0–5, seconds units 0–9), loads them on command, and then advances the time once per second from a clock-cycle prescaler. Its digit outputs feed the display path.

---
 rtl/watch_time_counter.sv | 63 ++++++
 tb/tb_watch_time_counter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/watch_time_counter.sv
// watch_time_counter: MM:SS BCD timekeeper with preset load and a one-second prescaler
// Ports: clk, rst (async, active high); load latches set_d0..set_d3 (out-of-range digits load as 0);
// run enables counting; d0..d3 = MM:SS digits; sec_tick pulses on each advance; wrap pulses on 59:59->00:00.
module watch_time_counter #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       run,
  input  logic [3:0] set_d0,
  input  logic [3:0] set_d1,
  input  logic [3:0] set_d2,
  input  logic [3:0] set_d3,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       sec_tick,
  output logic       wrap
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);
  logic [PW-1:0] pre;
  logic          tc, c3, c2, c1, c0;
  logic [3:0]    s0, s1, s2, s3, n0, n1, n2, n3;
  always_comb begin
    s0 = set_d0 > 4'd5 ? 4'd0 : set_d0;
    s1 = set_d1 > 4'd9 ? 4'd0 : set_d1;
    s2 = set_d2 > 4'd5 ? 4'd0 : set_d2;
    s3 = set_d3 > 4'd9 ? 4'd0 : set_d3;
    tc = pre == TERM;
    c3 = d3 == 4'd9;
    c2 = c3 && d2 == 4'd5;
    c1 = c2 && d1 == 4'd9;
    c0 = c1 && d0 == 4'd5;
    n3 = c3 ? 4'd0 : d3 + 4'd1;
    n2 = c3 ? (c2 ? 4'd0 : d2 + 4'd1) : d2;
    n1 = c2 ? (c1 ? 4'd0 : d1 + 4'd1) : d1;
    n0 = c1 ? (c0 ? 4'd0 : d0 + 4'd1) : d0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {d0, d1, d2, d3} <= '0;
      pre              <= '0;
      sec_tick         <= 1'b0;
      wrap             <= 1'b0;
    end else if (load) begin
      {d0, d1, d2, d3} <= {s0, s1, s2, s3};
      pre              <= '0;
      sec_tick         <= 1'b0;
      wrap             <= 1'b0;
    end else if (run) begin
      pre      <= tc ? '0 : pre + PW'(1);
      sec_tick <= tc;
      wrap     <= tc && c0;
      if (tc) {d0, d1, d2, d3} <= {n0, n1, n2, n3};
    end else begin
      sec_tick <= 1'b0;
      wrap     <= 1'b0;
    end
  end
endmodule

// File: tb/tb_watch_time_counter.sv
// tb_watch_time_counter: scoreboard bench for watch_time_counter with TICK_DIV=4
module tb_watch_time_counter;
  logic       clk = 1'b0, rst = 1'b1, load = 1'b0, run = 1'b0;
  logic [3:0] set_d0 = '0, set_d1 = '0, set_d2 = '0, set_d3 = '0;
  logic [3:0] d0, d1, d2, d3;
  logic       sec_tick, wrap;
  int         edges = 0, passed = 0, total = 0, b;
  typedef struct {
    string       name;
    bit          on_rst;
    int          at;
    logic [15:0] dig;
    logic        tick;
    logic        wr;
  } exp_t;
  exp_t q[$];
  watch_time_counter #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .run(run),
    .set_d0(set_d0), .set_d1(set_d1), .set_d2(set_d2), .set_d3(set_d3),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .sec_tick(sec_tick), .wrap(wrap)
  );
  always #5 clk = ~clk;
  function automatic void check(exp_t e);
    total++;
    if ({d0, d1, d2, d3} === e.dig && sec_tick === e.tick && wrap === e.wr) passed++;
    else $display("FAIL %s: got %h tick=%b wrap=%b, want %h tick=%b wrap=%b",
                  e.name, {d0, d1, d2, d3}, sec_tick, wrap, e.dig, e.tick, e.wr);
  endfunction
  always @(posedge clk) begin
    edges++;
    #1;
    while (q.size() > 0 && !q[0].on_rst && q[0].at < edges) begin
      total++;
      $display("FAIL %s: check at edge %0d never sampled", q[0].name, q[0].at);
      void'(q.pop_front());
    end
    if (q.size() > 0 && !q[0].on_rst && q[0].at == edges) check(q.pop_front());
    else if (sec_tick !== 1'b0) begin
      total++;
      $display("FAIL unexpected_tick: got sec_tick=%b at edge %0d, want 0", sec_tick, edges);
    end
  end
  always @(posedge rst) begin
    #1;
    if (q.size() > 0 && q[0].on_rst) check(q.pop_front());
  end
  task automatic push(input string name, input int at, input logic [15:0] dig,
                      input logic tick, input logic wr);
    q.push_back('{name, 1'b0, at, dig, tick, wr});
  endtask
  task automatic do_load(input logic [3:0] a, input logic [3:0] bb, input logic [3:0] c,
                         input logic [3:0] d, input logic r, output int base);
    @(negedge clk);
    load = 1'b1;
    run  = r;
    {set_d0, set_d1, set_d2, set_d3} = {a, bb, c, d};
    base = edges + 1;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push("reset_state", edges + 1, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    do_load(4'd0, 4'd9, 4'd5, 4'd9, 1'b1, b);
    push("load_0959", b, 16'h0959, 1'b0, 1'b0);
    push("pre_tc_0959", b + 3, 16'h0959, 1'b0, 1'b0);
    push("adv_1000", b + 4, 16'h1000, 1'b1, 1'b0);
    push("after_adv_1000", b + 5, 16'h1000, 1'b0, 1'b0);
    @(negedge clk);
    load = 1'b0;
    repeat (6) @(negedge clk);
    do_load(4'd5, 4'd9, 4'd5, 4'd9, 1'b1, b);
    push("load_5959", b, 16'h5959, 1'b0, 1'b0);
    push("wrap_0000", b + 4, 16'h0000, 1'b1, 1'b1);
    push("after_wrap", b + 5, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    load = 1'b0;
    repeat (6) @(negedge clk);
    do_load(4'd7, 4'd3, 4'd9, 4'd12, 1'b0, b);
    push("oor_load", b, 16'h0300, 1'b0, 1'b0);
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    do_load(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, b);
    push("load_1234", b, 16'h1234, 1'b0, 1'b0);
    push("pause_hold", b + 12, 16'h1234, 1'b0, 1'b0);
    push("resume_pre3", b + 13, 16'h1234, 1'b0, 1'b0);
    push("resume_adv", b + 14, 16'h1235, 1'b1, 1'b0);
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    run = 1'b0;
    repeat (10) @(negedge clk);
    run = 1'b1;
    repeat (3) @(negedge clk);
    do_load(4'd0, 4'd0, 4'd0, 4'd5, 1'b1, b);
    push("load_0005", b, 16'h0005, 1'b0, 1'b0);
    push("collision", b + 4, 16'h0000, 1'b0, 1'b0);
    push("coll_pre_tc", b + 7, 16'h0000, 1'b0, 1'b0);
    push("coll_adv", b + 8, 16'h0001, 1'b1, 1'b0);
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    load = 1'b1;
    {set_d0, set_d1, set_d2, set_d3} = 16'h0000;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    do_load(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, b);
    push("load_1234_rst", b, 16'h1234, 1'b0, 1'b0);
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    q.push_back('{"async_reset", 1'b1, 0, 16'h0000, 1'b0, 1'b0});
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run = 1'b0;
    rst = 1'b0;
    push("after_reset", edges + 1, 16'h0000, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    while (q.size() > 0) begin
      total++;
      $display("FAIL %s: expected entry never checked", q[0].name);
      void'(q.pop_front());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
